// File: rtl/snn_run_sequencer.sv
// Batch run controller for the SNN core: per sample it clears, runs the network for sim_time steps,
// drains, scans the spike counters for the winning neuron and reports it.
module snn_run_sequencer #(
  parameter int unsigned NUM_OUTPUTS  = 1,
  parameter int unsigned COUNTER_SIZE = 32
) (
  input  logic                                  S_AXI_ACLK,
  input  logic                                  S_AXI_ARESETN,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [15:0]                           num_samples,
  input  logic [31:0]                           sim_time,
  input  logic [NUM_OUTPUTS*COUNTER_SIZE-1:0]   spike_counts,
  output logic                                  net_rst,
  output logic                                  net_en,
  output logic [15:0]                           sample_idx,
  output logic                                  result_valid,
  output logic [7:0]                            result_winner,
  output logic [COUNTER_SIZE-1:0]               result_count,
  output logic                                  busy,
  output logic                                  done
);

  typedef enum logic [2:0] {
    StIdle, StClear, StRun, StDrain, StScan, StReport, StDone
  } state_e;

  localparam logic [7:0] LastIdx = 8'(NUM_OUTPUTS - 1);

  state_e                  r_state;
  logic [15:0]             r_num_samples;
  logic [31:0]             r_sim_time;
  logic [31:0]             r_run_cnt;
  logic [7:0]              r_scan_idx;
  logic [7:0]              r_best_idx;
  logic [COUNTER_SIZE-1:0] r_best_cnt;
  logic                    r_net_rst;
  logic                    r_net_en;
  logic [15:0]             r_sample_idx;
  logic                    r_result_valid;
  logic [7:0]              r_result_winner;
  logic [COUNTER_SIZE-1:0] r_result_count;
  logic                    r_busy;
  logic                    r_done;

  logic [COUNTER_SIZE-1:0] w_cur;
  logic                    w_take;
  logic [7:0]              w_best_idx;
  logic [COUNTER_SIZE-1:0] w_best_cnt;
  logic                    w_last_sample;

  always_comb begin
    w_cur = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (r_scan_idx == 8'(i)) w_cur = spike_counts[i*COUNTER_SIZE +: COUNTER_SIZE];
    end
  end

  // Neuron 0 seeds the running best; later neurons win only on a strictly greater count.
  assign w_take        = (r_scan_idx == 8'd0) || (w_cur > r_best_cnt);
  assign w_best_idx    = w_take ? r_scan_idx : r_best_idx;
  assign w_best_cnt    = w_take ? w_cur : r_best_cnt;
  assign w_last_sample = (r_sample_idx + 16'd1) == r_num_samples;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state         <= StIdle;
      r_num_samples   <= '0;
      r_sim_time      <= '0;
      r_run_cnt       <= '0;
      r_scan_idx      <= '0;
      r_best_idx      <= '0;
      r_best_cnt      <= '0;
      r_net_rst       <= 1'b0;
      r_net_en        <= 1'b0;
      r_sample_idx    <= '0;
      r_result_valid  <= 1'b0;
      r_result_winner <= '0;
      r_result_count  <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_net_rst      <= 1'b0;
      r_result_valid <= 1'b0;
      if (abort && r_state != StIdle) begin
        r_state  <= StIdle;
        r_net_en <= 1'b0;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle, StDone: begin
            if (start && !abort) begin
              r_num_samples <= num_samples;
              r_sim_time    <= sim_time;
              r_sample_idx  <= '0;
              if (num_samples == 16'd0) begin
                r_state <= StDone;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state   <= StClear;
                r_net_rst <= 1'b1;
                r_done    <= 1'b0;
                r_busy    <= 1'b1;
              end
            end
          end
          StClear: begin
            r_run_cnt <= '0;
            if (r_sim_time == 32'd0) begin
              r_state <= StDrain;
            end else begin
              r_state  <= StRun;
              r_net_en <= 1'b1;
            end
          end
          StRun: begin
            if (r_run_cnt == r_sim_time - 32'd1) begin
              r_state  <= StDrain;
              r_net_en <= 1'b0;
            end else begin
              r_run_cnt <= r_run_cnt + 32'd1;
            end
          end
          StDrain: begin
            r_state    <= StScan;
            r_scan_idx <= '0;
          end
          StScan: begin
            r_best_idx <= w_best_idx;
            r_best_cnt <= w_best_cnt;
            r_scan_idx <= r_scan_idx + 8'd1;
            if (r_scan_idx == LastIdx) begin
              r_state         <= StReport;
              r_result_winner <= w_best_idx;
              r_result_count  <= w_best_cnt;
              r_result_valid  <= 1'b1;
            end
          end
          StReport: begin
            r_sample_idx <= r_sample_idx + 16'd1;
            if (w_last_sample) begin
              r_state <= StDone;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= StClear;
              r_net_rst <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign net_rst       = r_net_rst;
  assign net_en        = r_net_en;
  assign sample_idx    = r_sample_idx;
  assign result_valid  = r_result_valid;
  assign result_winner = r_result_winner;
  assign result_count  = r_result_count;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: doc/snn_run_sequencer.md
# snn_run_sequencer

Batch run controller for the SNN core. Sequences a batch of input samples through the IF network: per sample it clears the network and spike counters, enables the spike generator and network for a programmed number of timesteps, then scans the output spike counters for the winning neuron and reports it. It sits between the AXI config registers (start/abort/num_samples/sim_time/results) and the network datapath (network reset, enable, spike generator page select, spike counter outputs). It replaces the free-running sim-time counter compare.

## Interface
Parameters:
- NUM_OUTPUTS, 1: output neurons / spike counters scanned; 1..256
- COUNTER_SIZE, 32: width of each spike counter

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  reset; asynchronous, active-low
- start  in  1  begin batch; accepted only in IDLE or DONE
- abort  in  1  terminate batch; returns to IDLE
- num_samples  in  16  samples per batch; latched on start
- sim_time  in  32  enabled timesteps per sample; latched on start
- spike_counts  in  NUM_OUTPUTS*COUNTER_SIZE  flattened counters, neuron i at [i*COUNTER_SIZE +: COUNTER_SIZE]
- net_rst  out  1  network and spike counter clear
- net_en  out  1  spike generator / network enable
- sample_idx  out  16  current sample; selects spike generator probability page
- result_valid  out  1  one-cycle pulse per completed sample
- result_winner  out  8  index of winning neuron
- result_count  out  COUNTER_SIZE  spike count of winner
- busy  out  1  high in any state other than IDLE and DONE
- done  out  1  level; batch completed

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, SCAN, REPORT, DONE.
- IDLE/DONE + start: latch num_samples, sim_time; sample_idx<=0; done<=0; next CLEAR, or DONE if num_samples==0.
- CLEAR (1 cycle): net_rst=1; run counter<=0; next RUN, or DRAIN if sim_time==0.
- RUN: net_en=1; counter increments; leaves to DRAIN after exactly sim_time cycles.
- DRAIN (1 cycle): net_en=0; lets last-timestep spikes reach counters.
- SCAN: one neuron per cycle, i=0..NUM_OUTPUTS-1; best initialised from neuron 0; replace only on strictly greater count (tie -> lowest index). All-zero counts -> winner 0, count 0.
- REPORT (1 cycle): result_winner/result_count registered, result_valid=1; sample_idx+1; next DONE if sample_idx+1==num_samples, else CLEAR.
- DONE: done=1, holds; counters not cleared (remain AXI-readable).
- abort in any state except IDLE: next state IDLE, net_en=0 that next cycle, no result_valid, done stays 0; sample_idx holds. abort and start together: abort wins, stays/returns IDLE.
- start outside IDLE/DONE ignored. Input changes to num_samples/sim_time after start have no effect.
- result_winner/result_count hold last reported value until next REPORT.
- Unsigned compares; counter widths as declared; result_winner zero-extended index.

## Timing
- Reset (async assert, sync release): state IDLE; net_rst, net_en, result_valid, busy, done = 0; sample_idx, result_winner, result_count = 0.
- start sampled at edge T0: CLEAR in cycle T1, net_en high cycles T2..T2+S-1 (S=sim_time), DRAIN T2+S, SCAN N cycles (N=NUM_OUTPUTS), REPORT follows.
- Per-sample period: S+N+3 cycles; batch of M samples: M*(S+N+3) cycles from T1; done rises the cycle after last REPORT.
- net_en high exactly S cycles per sample; net_rst exactly 1 cycle per sample.
- sample_idx stable for the whole CLEAR..REPORT window of its sample; updates at end of REPORT.
- All outputs registered; no combinational input-to-output paths.

## Test plan
- NUM_OUTPUTS=4, num_samples=1, sim_time=10, counts {3,9,2,5}: one net_rst pulse, net_en high 10 cycles, result_valid once with winner 1, count 9, done 1 cycle later; total 17 cycles from CLEAR.
- num_samples=3, sim_time=5: three result_valid pulses 12 cycles apart, sample_idx 0,1,2 during runs, 3 in DONE.
- Ties {7,7,0,7} -> winner 0; all-zero -> winner 0, count 0; max at last index {1,1,1,8} -> winner 3.
- sim_time=0 -> CLEAR then DRAIN, net_en never high; num_samples=0 -> DONE next cycle, no net_rst, no result_valid.
- abort mid-RUN -> IDLE next cycle, net_en low, no result_valid, done 0; start in same cycle as abort ignored; new start afterwards runs normally from sample 0.
- Assert S_AXI_ARESETN low mid-SCAN -> all outputs 0 immediately; after release, start re-runs cleanly.
